// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
// Contents:
//   RF_WIDTH / RF_DEPTH / RF_LINK_REG : default data width, register count, link index
//   rf_state_e                        : RF_SCRUB while zeroing the array, RF_RUN once usable
//   pc_link(pc)                       : return address of a linking instruction (pc + 4)
package rf_pkg;

   localparam int RF_WIDTH    = 32;
   localparam int RF_DEPTH    = 32;
   localparam int RF_LINK_REG = 31;

   typedef enum logic {
      RF_SCRUB = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

   // Computed at 64 bits so any data width up to 64 can truncate the result and
   // get the wrap-around (mod 2^WIDTH) behaviour for free.
   function automatic logic [63:0] pc_link(input logic [63:0] pc);
      return pc + 64'd4;
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between the decode/writeback stages and the register file.
// Parameters: WIDTH (data bits), DEPTH (register count), NRD (read ports).
// Signals:
//   ra/rd/rd_busy       : NRD packed read ports (address, data, pending flag)
//   we/wa/wd            : writeback port
//   lr_we/pc            : link-register write, stores pc + 4
//   iss_we/iss_wa       : issue, marks a destination register pending
//   ready               : low while the array is being scrubbed
// Modports: master = pipeline side, slave = register file side.
interface register_file_mp_if
   import rf_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(DEPTH);

   logic [NRD*AW-1:0]    ra;
   logic [NRD*WIDTH-1:0] rd;
   logic [NRD-1:0]       rd_busy;
   logic                 we;
   logic [AW-1:0]        wa;
   logic [WIDTH-1:0]     wd;
   logic                 lr_we;
   logic [WIDTH-1:0]     pc;
   logic                 iss_we;
   logic [AW-1:0]        iss_wa;
   logic                 ready;

   modport master (
      output ra, we, wa, wd, lr_we, pc, iss_we, iss_wa,
      input  rd, rd_busy, ready
   );

   modport slave (
      input  ra, we, wa, wd, lr_we, pc, iss_we, iss_wa,
      output rd, rd_busy, ready
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits used for hazard stalls.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (clears every bit)
//   setEn/setAddr     : issue of a new destination, marks it pending
//   clrEn/clrAddr     : writeback completes, clears the destination
//   lrClr             : link write completes, clears LINK_REG
//   lookupAddr/busy   : NRD combinational lookup ports
// Callers gate the enables themselves (nothing is tracked while scrubbing).
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int DEPTH    = RF_DEPTH,
   parameter int NRD      = 2,
   parameter int LINK_REG = RF_LINK_REG,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              setEn,
   input  logic [AW-1:0]     setAddr,
   input  logic              clrEn,
   input  logic [AW-1:0]     clrAddr,
   input  logic              lrClr,
   input  logic [NRD*AW-1:0] lookupAddr,
   output logic [NRD-1:0]    busy
);

   localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

   logic [DEPTH-1:0] pending;
   logic [DEPTH-1:0] pendingNext;

   // Clears are applied first so that an issue landing on the same register in
   // the same cycle survives: the issue belongs to a newer instruction whose
   // result is still outstanding. Register 0 is never marked pending.
   always_comb begin
      pendingNext = pending;
      if (clrEn) begin
         pendingNext[clrAddr] = 1'b0;
      end
      if (lrClr) begin
         pendingNext[LINK_ADDR] = 1'b0;
      end
      if (setEn && setAddr != '0) begin
         pendingNext[setAddr] = 1'b1;
      end
   end

   // Pending state register; reset drops every outstanding hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= pendingNext;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : gLookup
      assign busy[k] = pending[lookupAddr[k*AW +: AW]];
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with link port, pending scoreboard and
// post-reset scrub sequencer.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset; restarts the scrub and drops pending bits
//   bus    : register_file_mp_if.slave (read ports, writeback, link, issue, ready)
// After reset the array is zeroed one entry per cycle; ready rises when the
// last entry has been written. Register 0 always reads as zero.
// Optional macro RF_BYPASS_EN: same-cycle forwarding of the link and writeback
// data to every read port (link data has priority), with rd_busy forced low on
// a forwarded read. Without it, a written value is visible the following cycle.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter int NRD      = 2,
   parameter int LINK_REG = RF_LINK_REG
) (
   input  logic                clk,
   input  logic                rst_n,
   register_file_mp_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   rf_state_e        state;
   rf_state_e        stateNext;
   logic [AW-1:0]    scrubCnt;
   logic [AW-1:0]    scrubCntNext;
   logic             running;
   logic [WIDTH-1:0] linkData;
   logic [NRD-1:0]   rawBusy;
   logic [WIDTH-1:0] regs [DEPTH];

   assign running  = (state == RF_RUN);
   assign linkData = WIDTH'(pc_link(64'(bus.pc)));
   assign bus.ready = running;

   // Scrub sequencer state register. Reset always restarts the scrub from
   // entry 0, whether it hits mid-scrub or during normal operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RF_SCRUB;
         scrubCnt <= '0;
      end else begin
         state    <= stateNext;
         scrubCnt <= scrubCntNext;
      end
   end

   // Step through every entry once; leave for RUN on the cycle that writes the
   // last entry, so ready rises exactly DEPTH edges after reset release.
   always_comb begin
      stateNext    = state;
      scrubCntNext = scrubCnt;
      case (state)
         RF_SCRUB: begin
            scrubCntNext = scrubCnt + 1'b1;
            if (scrubCnt == LAST_ADDR) begin
               stateNext = RF_RUN;
            end
         end
         RF_RUN: begin
            stateNext = RF_RUN;
         end
         default: begin
            stateNext = RF_SCRUB;
         end
      endcase
   end

   // Array write port. While scrubbing only the zeroing write happens. In RUN
   // the link write is issued after the writeback so it wins a collision on
   // LINK_REG. Writes to register 0 are discarded.
   always_ff @(posedge clk) begin
      if (state == RF_SCRUB) begin
         regs[scrubCnt] <= '0;
      end else begin
         if (bus.we && bus.wa != '0) begin
            regs[bus.wa] <= bus.wd;
         end
         if (bus.lr_we) begin
            regs[LINK_ADDR] <= linkData;
         end
      end
   end

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .NRD      (NRD),
      .LINK_REG (LINK_REG)
   ) uScoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .setEn      (bus.iss_we && running),
      .setAddr    (bus.iss_wa),
      .clrEn      (bus.we && running),
      .clrAddr    (bus.wa),
      .lrClr      (bus.lr_we && running),
      .lookupAddr (bus.ra),
      .busy       (rawBusy)
   );

   for (genvar k = 0; k < NRD; k++) begin : gRead
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
      logic             busy;

      assign addr = bus.ra[k*AW +: AW];

      // Read mux for port k: zero while scrubbing and for register 0,
      // otherwise the array entry (or forwarded write data when enabled).
      always_comb begin
         data = '0;
         busy = 1'b0;
         if (running && addr != '0) begin
`ifdef RF_BYPASS_EN
            if (bus.lr_we && addr == LINK_ADDR) begin
               data = linkData;
            end else if (bus.we && bus.wa == addr) begin
               data = bus.wd;
            end else begin
               data = regs[addr];
               busy = rawBusy[k];
            end
`else
            data = regs[addr];
            busy = rawBusy[k];
`endif
         end
      end

      assign bus.rd[k*WIDTH +: WIDTH] = data;
      assign bus.rd_busy[k]           = busy;
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (WIDTH 32, DEPTH 32, NRD 2, LINK_REG 31).
// A behavioural model predicts every cycle's read results; predictions are
// queued when stimulus is driven and popped when the outputs are sampled.
module tb_register_file_mp;

   logic clk;
   logic rst_n;

   register_file_mp_if #(.WIDTH(32), .DEPTH(32), .NRD(2)) bus ();

   register_file_mp #(
      .WIDTH    (32),
      .DEPTH    (32),
      .NRD      (2),
      .LINK_REG (31)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  busy;
      logic        ready;
   } exp_t;

   exp_t        expQ[$];
   int          checkCount = 0;
   int          errorCount = 0;

   logic [31:0] modelRegs [32];
   logic [31:0] modelPend;
   bit          modelRun;
   int          modelCnt;

   logic [31:0] lastRd0;
   logic [31:0] lastRd1;
   logic [1:0]  lastBusy;
   logic        lastReady;

   // Single comparison point: counts and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      modelRun  = 1'b0;
      modelCnt  = 0;
      modelPend = '0;
   endtask

   // Expected combinational read for one port, given the current drive.
   task automatic modelRead(input logic [4:0] addr, input logic weIn, input logic [4:0] waIn,
                            input logic [31:0] wdIn, input logic lrIn, input logic [31:0] pcIn,
                            output logic [31:0] data, output logic busy);
      data = '0;
      busy = 1'b0;
      if (modelRun && addr != 5'd0) begin
         data = modelRegs[addr];
         busy = modelPend[addr];
`ifdef RF_BYPASS_EN
         if (lrIn && addr == 5'd31) begin
            data = pcIn + 32'd4;
            busy = 1'b0;
         end else if (weIn && waIn == addr) begin
            data = wdIn;
            busy = 1'b0;
         end
`endif
      end
   endtask

   // Pops the oldest prediction and compares it with the sampled outputs.
   task automatic compareCycle();
      exp_t e;
      if (expQ.size() == 0) begin
         checkOutput("queue_empty", 32'd1, 32'd0);
      end else begin
         e = expQ.pop_front();
         lastRd0   = bus.rd[31:0];
         lastRd1   = bus.rd[63:32];
         lastBusy  = bus.rd_busy;
         lastReady = bus.ready;
         checkOutput("rd0", lastRd0, e.rd0);
         checkOutput("rd1", lastRd1, e.rd1);
         checkOutput("rd_busy", {30'd0, lastBusy}, {30'd0, e.busy});
         checkOutput("ready", {31'd0, lastReady}, {31'd0, e.ready});
      end
   endtask

   // One clock cycle: drive at posedge+1, predict, sample at posedge+6,
   // then advance the model across the next rising edge.
   task automatic applyStimulus(input logic rstIn, input logic weIn, input logic [4:0] waIn,
                                input logic [31:0] wdIn, input logic lrIn, input logic [31:0] pcIn,
                                input logic issIn, input logic [4:0] issWaIn,
                                input logic [4:0] ra0In, input logic [4:0] ra1In);
      exp_t e;
      logic b0, b1;
      rst_n       = rstIn;
      bus.we      = weIn;
      bus.wa      = waIn;
      bus.wd      = wdIn;
      bus.lr_we   = lrIn;
      bus.pc      = pcIn;
      bus.iss_we  = issIn;
      bus.iss_wa  = issWaIn;
      bus.ra      = {ra1In, ra0In};
      if (!rstIn) modelReset();
      modelRead(ra0In, weIn, waIn, wdIn, lrIn, pcIn, e.rd0, b0);
      modelRead(ra1In, weIn, waIn, wdIn, lrIn, pcIn, e.rd1, b1);
      e.busy  = {b1, b0};
      e.ready = modelRun;
      expQ.push_back(e);
      #5;
      compareCycle();
      @(posedge clk);
      if (!rstIn) begin
         modelReset();
      end else if (!modelRun) begin
         modelRegs[modelCnt] = '0;
         if (modelCnt == 31) modelRun = 1'b1;
         modelCnt++;
      end else begin
         if (weIn && waIn != 5'd0) modelRegs[waIn] = wdIn;
         if (lrIn) modelRegs[31] = pcIn + 32'd4;
         if (weIn) modelPend[waIn] = 1'b0;
         if (lrIn) modelPend[31] = 1'b0;
         if (issIn && issWaIn != 5'd0) modelPend[issWaIn] = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input logic [4:0] ra0In, input logic [4:0] ra1In);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, ra0In, ra1In);
   endtask

   // Full scrub after release, with writes and issues driven the whole time;
   // ready must stay low for 32 samples and be high on the next one.
   task automatic scrubAndCount(input string tag);
      int zeros = 0;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 1'b1, 5'd5, 32'hBAD0_0000 + i, 1'b1, 32'h100, 1'b1, 5'd6,
                       5'(i), 5'd5);
         if (lastReady == 1'b0) zeros++;
      end
      checkOutput({tag, "_ready_low_cycles"}, 32'(zeros), 32'd32);
      idle(5'd5, 5'd6);
      checkOutput({tag, "_ready_high"}, {31'd0, lastReady}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) modelRegs[i] = 'x;
      modelReset();
      rst_n = 1'b0;
      bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.lr_we = 1'b0; bus.pc = '0;
      bus.iss_we = 1'b0; bus.iss_wa = '0; bus.ra = '0;
      @(posedge clk);
      #1;

      // Reset held, then released into a full scrub.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, 5'd5, 32'h1111, 1'b0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
      checkOutput("reset_ready", {31'd0, lastReady}, 32'd0);
      scrubAndCount("t1");
      for (int i = 0; i < 16; i++) begin
         idle(5'(i), 5'(i + 16));
         checkOutput("t1_zero_lo", lastRd0, 32'd0);
         checkOutput("t1_zero_hi", lastRd1, 32'd0);
      end

      // Writeback visibility, same cycle vs next cycle.
      applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
`ifdef RF_BYPASS_EN
      checkOutput("t2_same_cycle", lastRd0, 32'hDEADBEEF);
`else
      checkOutput("t2_same_cycle", lastRd0, 32'd0);
`endif
      idle(5'd5, 5'd0);
      checkOutput("t2_next_cycle", lastRd0, 32'hDEADBEEF);

      // Link and writeback collide on r31; link wins and wraps to zero.
      applyStimulus(1'b1, 1'b1, 5'd31, 32'd7, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 5'd31, 5'd31);
      idle(5'd31, 5'd5);
      checkOutput("t3_link_wrap", lastRd0, 32'h0000_0000);

      // Pending scoreboard set, clear, and same-cycle set-over-clear.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd3);
      idle(5'd0, 5'd3);
      checkOutput("t4_busy_set", {30'd0, lastBusy}, 32'd2);
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      idle(5'd0, 5'd3);
      checkOutput("t4_busy_clr", {30'd0, lastBusy}, 32'd0);
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h44, 1'b0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
      idle(5'd0, 5'd3);
      checkOutput("t4_set_wins", {30'd0, lastBusy}, 32'd2);

      // Register 0 ignores writes and issues.
      applyStimulus(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
      idle(5'd0, 5'd0);
      checkOutput("t5_r0_data", lastRd0, 32'd0);
      checkOutput("t5_r0_busy", {30'd0, lastBusy}, 32'd0);

      // Randomised traffic against the model.
      for (int i = 0; i < 80; i++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                       1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)));
      end

      // Reset mid-scrub at scrub count 10.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 10; i++) idle(5'd5, 5'd3);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd3);
      scrubAndCount("t6a");

      // Reset mid-run with pending bits set.
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
      idle(5'd3, 5'd9);
      checkOutput("t6b_pending_before", {30'd0, lastBusy}, 32'd3);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9);
      scrubAndCount("t6b");
      idle(5'd3, 5'd9);
      checkOutput("t6b_pending_cleared", {30'd0, lastBusy}, 32'd0);
      checkOutput("t6b_r9_zeroed", lastRd1, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
